// File: rtl/rv32_pkg.sv
// Shared RV32 core types and constants used by the instruction-fetch front end.
package rv32_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_ibuf.sv
// Two-entry synchronous instruction queue between fetch and the IF/ID register.
// Flush discards all entries; a push into a full queue is only accepted when the
// same cycle pops, so an entry is never overwritten before it is consumed.
module if_ibuf
  import rv32_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  // Qualify push/pop against current occupancy.
  always_comb begin
    do_pop  = pop & (count_q != 2'd0);
    do_push = push & ((count_q != 2'd2) | do_pop);
  end

  // Storage, pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential or redirected
// requests to instruction memory and queues returned words for the ID stage.
// Optional feature macro IF_MISALIGN_TRAP_EN: a misaligned redirect target raises the
// sticky if_misalign_o and freezes fetching until the next redirect or reset.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
`ifdef IF_MISALIGN_TRAP_EN
  output logic        if_misalign_o,
`endif
  input  logic        id_ready_i
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  tag_q, tag_d;
  logic         outstanding_q, outstanding_d;
  logic         kill_q, kill_d;
  logic [31:0]  target_pc;
  logic         frozen;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         pop;
  logic         push;
  logic         grant;
  logic         landed;
  logic         pending;
  logic [2:0]   used;

  assign target_pc = {redirect_pc_i[31:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Every redirect re-evaluates the trap; otherwise it is sticky.
  always_comb begin
    misalign_d = misalign_q;
    if (redirect_i) begin
      misalign_d = |redirect_pc_i[1:0];
    end
  end

  // Misalign flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign frozen        = misalign_q;
  assign if_misalign_o = misalign_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign frozen        = 1'b0;
`endif

  // Request gating: a response in flight already owns a queue slot, unless it is
  // marked for discard, so every granted request is guaranteed somewhere to land.
  always_comb begin
    pop        = if_valid_o & id_ready_i;
    landed     = imem_rvalid_i & outstanding_q;
    pending    = outstanding_q & ~kill_q;
    used       = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    imem_req_o = rst_n & ~redirect_i & ~frozen & (used < 3'd2);
    grant      = imem_req_o & imem_gnt_i;
    push       = landed & ~kill_q & ~redirect_i;
    push_entry.pc    = tag_q;
    push_entry.instr = imem_rdata_i;
  end

  // Next fetch PC, response tag, outstanding and kill tracking; redirect wins.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    tag_d         = tag_q;
    outstanding_d = outstanding_q & ~imem_rvalid_i;
    kill_d        = kill_q;
    if (redirect_i) begin
      fetch_pc_d = target_pc;
      // A response landing this cycle is dropped by the flush; only a later one needs killing.
      kill_d     = outstanding_q & ~imem_rvalid_i;
    end else begin
      if (landed) begin
        kill_d = 1'b0;
      end
      if (grant) begin
        tag_d         = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
        outstanding_d = 1'b1;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      tag_q         <= '0;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

  if_ibuf u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign imem_addr_o = fetch_pc_q;
  assign if_valid_o  = (count != 2'd0);
  assign if_pc_o     = if_valid_o ? head.pc : '0;
  assign if_instr_o  = if_valid_o ? head.instr : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a one-cycle-latency memory model and a
// scoreboard of expected {pc, instr} entries pushed on grant and popped on consume.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        id_ready_i;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misalign_o;
`endif

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
`ifdef IF_MISALIGN_TRAP_EN
    .if_misalign_o (if_misalign_o),
`endif
    .id_ready_i    (id_ready_i)
  );

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  int unsigned  n_grants = 0;
  fetch_entry_t exp_q[$];
  logic [31:0]  pop_log[$];
  logic         pend_valid;
  logic [31:0]  pend_data;
  logic         s_req;
  logic         s_valid;
  logic [31:0]  s_addr;
  logic [31:0]  s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample, update scoreboard and memory model.
  task automatic cycle(input logic gnt, input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic spur);
    fetch_entry_t e;
    imem_gnt_i    = gnt;
    id_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_rvalid_i = pend_valid | spur;
    imem_rdata_i  = pend_valid ? pend_data : 32'hDEAD_BEEF;
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = if_valid_o;
    s_pc    = if_pc_o;
    if (redir) check_eq("req_in_redirect", 32'(imem_req_o), 32'd0);
    if (if_valid_o && rdy && !redir) begin
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("if_pc", if_pc_o, e.pc);
        check_eq("if_instr", if_instr_o, e.instr);
      end
      pop_log.push_back(if_pc_o);
    end
    if (redir) exp_q.delete();
    pend_valid = imem_req_o & gnt;
    pend_data  = mem_word(imem_addr_o);
    if (pend_valid) begin
      exp_q.push_back('{pc: imem_addr_o, instr: mem_word(imem_addr_o)});
      n_grants++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    id_ready_i    = 1'b0;
    pend_valid    = 1'b0;
    pend_data     = '0;
    exp_q.delete();
    pop_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_valid", 32'(if_valid_o), 32'd0);
    check_eq("rst_addr", imem_addr_o, 32'h0000_0000);
    check_eq("rst_instr", if_instr_o, 32'd0);
    check_eq("rst_pc", if_pc_o, 32'd0);
    rst_n = 1'b1;
  endtask

  // Let all in-flight and queued words drain, then confirm nothing is left over.
  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      if (!if_valid_o && !pend_valid) break;
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    end
    check_eq("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("drain_valid", 32'(if_valid_o), 32'd0);
  endtask

  initial begin
    int unsigned g0;

    // Sequential fetch after reset.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("seq_addr0", s_addr, 32'h0);
    check_eq("seq_req0", 32'(s_req), 32'd1);
    check_eq("seq_valid0", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("seq_addr1", s_addr, 32'h4);
    check_eq("seq_valid1", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("seq_addr2", s_addr, 32'h8);
    check_eq("seq_valid2", 32'(s_valid), 32'd1);
    check_eq("seq_pc2", s_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("stream_valid", 32'(s_valid), 32'd1);
      check_eq("stream_req", 32'(s_req), 32'd1);
    end
    drain();

    // Backpressure: queue fills to two, requests stop, order kept on release.
    do_reset();
    g0 = n_grants;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check_eq("stall_grants", n_grants - g0, 32'd2);
    check_eq("stall_req_off", 32'(s_req), 32'd0);
    check_eq("stall_valid", 32'(s_valid), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    drain();
    check_eq("stall_log_len", 32'(pop_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 3) begin
      check_eq("stall_pop0", pop_log[0], 32'h0);
      check_eq("stall_pop1", pop_log[1], 32'h4);
      check_eq("stall_pop2", pop_log[2], 32'h8);
    end

    // Redirect while a request is outstanding.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("redir_addr", s_addr, 32'h100);
    check_eq("redir_req", 32'(s_req), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("redir_no_stale", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("redir_valid", 32'(s_valid), 32'd1);
    check_eq("redir_pc", s_pc, 32'h100);
    drain();

    // Grant withheld: request and address hold steady.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("nognt_req", 32'(s_req), 32'd1);
      check_eq("nognt_addr", s_addr, 32'h0);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("nognt_next", s_addr, 32'h4);
    drain();

    // Fetch PC wrap at the top of the address space.
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("wrap_top", s_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("wrap_zero", s_addr, 32'h0);
    drain();

    // Stray response with nothing outstanding is ignored.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("stray_valid", 32'(s_valid), 32'd0);

`ifdef IF_MISALIGN_TRAP_EN
    // Misaligned redirect freezes fetching until an aligned redirect.
    do_reset();
    check_eq("mis_rst", 32'(if_misalign_o), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h102, 1'b0);
    check_eq("mis_set", 32'(if_misalign_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      check_eq("mis_frozen", 32'(s_req), 32'd0);
    end
    cycle(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    check_eq("mis_clear", 32'(if_misalign_o), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("mis_resume_req", 32'(s_req), 32'd1);
    check_eq("mis_resume_addr", s_addr, 32'h200);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
